// File: rtl/bldc_pkg.sv
// Shared definitions for the six-step BLDC commutator: gate indices, FSM
// encoding, invalid hall codes and the hall-to-gate commutation table.
package bldc_pkg;

  // Gate vector bit positions, {HA,LA,HB,LB,HC,LC}
  localparam int unsigned GATE_HA = 5;
  localparam int unsigned GATE_LA = 4;
  localparam int unsigned GATE_HB = 3;
  localparam int unsigned GATE_LB = 2;
  localparam int unsigned GATE_HC = 1;
  localparam int unsigned GATE_LC = 0;

  // Dead-time FSM encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StDead  = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  localparam logic [2:0] HALL_INVALID_0 = 3'b000;
  localparam logic [2:0] HALL_INVALID_1 = 3'b111;

  function automatic logic [5:0] gate_pair(input int unsigned hi, input int unsigned lo);
    logic [5:0] g;
    g = '0;
    g[hi] = 1'b1;
    g[lo] = 1'b1;
    return g;
  endfunction

  // Exchange high and low side of every phase (reverse direction / complement lookup)
  function automatic logic [5:0] swap_pairs(input logic [5:0] g);
    return {g[4], g[5], g[2], g[3], g[0], g[1]};
  endfunction

  function automatic logic hall_is_invalid(input logic [2:0] hall);
    return (hall == HALL_INVALID_0) || (hall == HALL_INVALID_1);
  endfunction

  // Forward table; reverse is the same table with each phase's H/L swapped
  function automatic logic [5:0] commutate(input logic [2:0] hall, input logic dir);
    logic [5:0] g;
    case (hall)
      3'b101:  g = gate_pair(GATE_HA, GATE_LB);
      3'b100:  g = gate_pair(GATE_HA, GATE_LC);
      3'b110:  g = gate_pair(GATE_HB, GATE_LC);
      3'b010:  g = gate_pair(GATE_HB, GATE_LA);
      3'b011:  g = gate_pair(GATE_HC, GATE_LA);
      3'b001:  g = gate_pair(GATE_HC, GATE_LB);
      default: g = '0;
    endcase
    return dir ? swap_pairs(g) : g;
  endfunction

endpackage

// File: rtl/bldc_commutator_hall_filter.sv
// Hall input conditioning: 2-flop synchroniser per bit, then a code is
// accepted only after HALL_FILTER consecutive identical synchronised samples.
module hall_filter #(
  parameter int unsigned HALL_FILTER = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] hall_i,
  output logic [2:0] hall_o,
  output logic       seen_o
);

  localparam int unsigned RunW = $clog2(HALL_FILTER + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(HALL_FILTER);

  logic [2:0]      sync1_q, sync2_q, cand_q, cand_d, state_q, state_d;
  logic [RunW-1:0] run_q, run_d;
  logic [1:0]      vld_q;
  logic            seen_q, seen_d;

  // Count identical samples; vld_q keeps the synchroniser's reset contents from counting
  always_comb begin
    cand_d  = cand_q;
    run_d   = run_q;
    state_d = state_q;
    seen_d  = seen_q;
    if (vld_q[1]) begin
      cand_d = sync2_q;
      if (sync2_q != cand_q) begin
        run_d = RunW'(1);
      end else if (run_q != RunMax) begin
        run_d = run_q + RunW'(1);
      end
      if (run_d == RunMax) begin
        state_d = sync2_q;
        seen_d  = 1'b1;
      end
    end
  end

  // Synchroniser, debounce counter and accepted code
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
      cand_q  <= '0;
      run_q   <= '0;
      state_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      cand_q  <= cand_d;
      run_q   <= run_d;
      state_q <= state_d;
      seen_q  <= seen_d;
    end
  end

  assign hall_o = state_q;
  assign seen_o = seen_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation stage: PWM counter with period-aligned duty latch,
// commutation target mux, dead-time FSM for the six gate drives, and a sticky
// invalid-hall fault.
module bldc_commutator import bldc_pkg::*; #(
  parameter int unsigned PWM_BITS    = 9,
  parameter int unsigned DEADTIME    = 8,
  parameter int unsigned HALL_FILTER = 4
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                hall1,
  input  logic                hall2,
  input  logic                hall3,
  input  logic [PWM_BITS-1:0] pwm,
  input  logic                enable,
  input  logic                brake,
  input  logic                clear_fault,
  output logic [5:0]          GATES,
  output logic                fault,
  output logic [2:0]          hall_state,
  output logic                period_tick
);

  localparam int unsigned CntW = PWM_BITS - 1;
  localparam int unsigned DtW  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DtW-1:0] DtLoad = DtW'(DEADTIME - 1);

  logic [CntW-1:0]     cnt_q, mag_q, mag_d;
  logic                dir_q, tick_q, wrap;
  logic [PWM_BITS-1:0] pwm_neg, pwm_abs;
  logic [2:0]          hall_acc;
  logic                hall_seen, fault_set, fault_q, fault_d, on;
  logic [5:0]          target, new_on, gates_q, gates_d;
  logic [1:0]          state_q, state_d;
  logic [DtW-1:0]      dtcnt_q, dtcnt_d;

  hall_filter #(
    .HALL_FILTER(HALL_FILTER)
  ) u_hall_filter (
    .clk_i  (CLK),
    .rst_i  (reset),
    .hall_i ({hall1, hall2, hall3}),
    .hall_o (hall_acc),
    .seen_o (hall_seen)
  );

  // |pwm| with the most-negative code saturated into the magnitude range
  always_comb begin
    pwm_neg = -pwm;
    pwm_abs = pwm[PWM_BITS-1] ? pwm_neg : pwm;
    mag_d   = pwm_abs[PWM_BITS-1] ? '1 : pwm_abs[CntW-1:0];
  end

  assign wrap = (cnt_q == '1);
  assign on   = (cnt_q < mag_q);

  // Free-running counter; duty and direction only change at the period boundary
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      mag_q  <= '0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
      tick_q <= wrap;
      if (wrap) begin
        mag_q <= mag_d;
        dir_q <= pwm[PWM_BITS-1];
      end
    end
  end

  // Sticky fault; an invalid accepted code outranks a simultaneous clear
  always_comb begin
    fault_set = hall_seen && hall_is_invalid(hall_acc);
    fault_d   = fault_set || (fault_q && !clear_fault);
  end

  // Desired gate pattern before dead-time sequencing
  always_comb begin
    target = '0;
    if (fault_q || !enable) begin
      target = '0;
    end else if (brake) begin
      target[GATE_LA] = 1'b1;
      target[GATE_LB] = 1'b1;
      target[GATE_LC] = 1'b1;
    end else if (on) begin
      target = commutate(hall_acc, dir_q);
    end
  end

  // Dead-time sequencing: turn-offs pass at once, any turn-on waits DEADTIME clocks
  always_comb begin
    state_d = state_q;
    gates_d = gates_q;
    dtcnt_d = dtcnt_q;
    new_on  = target & ~gates_q;
    if (fault_q || !enable) begin
      gates_d = '0;
      dtcnt_d = '0;
      state_d = fault_q ? StFault : StIdle;
    end else begin
      case (state_q)
        StDead: begin
          if (dtcnt_q != '0) begin
            gates_d = gates_q & target;
            dtcnt_d = dtcnt_q - DtW'(1);
          end else if ((new_on & swap_pairs(gates_q)) != '0) begin
            // Target flipped a phase at the last moment: its partner is still on
            gates_d = gates_q & target;
            dtcnt_d = DtLoad;
          end else begin
            gates_d = target;
            state_d = (target == '0) ? StIdle : StDrive;
          end
        end
        StFault: begin
          gates_d = '0;
          state_d = StIdle;
        end
        default: begin
          if (new_on != '0) begin
            gates_d = gates_q & target;
            dtcnt_d = DtLoad;
            state_d = StDead;
          end else begin
            gates_d = target;
            state_d = (target == '0) ? StIdle : StDrive;
          end
        end
      endcase
    end
  end

  // FSM, gate and fault registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gates_q <= '0;
      dtcnt_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gates_q <= gates_d;
      dtcnt_q <= dtcnt_d;
      fault_q <= fault_d;
    end
  end

  assign GATES       = gates_q;
  assign fault       = fault_q;
  assign hall_state  = hall_acc;
  assign period_tick = tick_q;

endmodule
